sorter_leaf_buffer: RTL

Parametrised leaf input buffer for the merge sorter tree, successor to the fixed 32-bit / 16-record leaf. It buffers an upstream record stream in a small first-word-fall-through FIFO and forwards exactly `cfg_len` records per run into the leaf merger FIFO. After that it emits a sentinel until the next run is started. Unlike the fixed leaf, it supports repeated runs without reset, programmable run length, configurable width and depth, and overflow detection.

---
 rtl/sorter_leaf_buffer_pkg.sv | 22 ++
 rtl/sorter_leaf_buffer_if.sv | 17 +
 rtl/sorter_leaf_buffer_sync_fifo_fwft.sv | 48 ++++
 rtl/sorter_leaf_buffer.sv | 84 ++++++++
 4 files changed

// File: rtl/sorter_leaf_buffer_pkg.sv
// Shared definitions for the merge sorter leaf: leaf FSM encoding, default width
// and the sentinel word used to pad a finished run.
package sorter_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned SENT_MAX_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PAD  = 2'd2
    } leaf_state_t;

    // All-ones pattern of dw bits; callers take the low dw bits of the result.
    function automatic logic [SENT_MAX_W-1:0] sentinel_word(input int unsigned dw);
        sentinel_word = '0;
        for (int i = 0; i < int'(SENT_MAX_W); i++) begin
            if (i < int'(dw)) sentinel_word[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/sorter_leaf_buffer_if.sv
// Record stream bundle around the leaf buffer: upstream write side (din/i_enq/i_full)
// and downstream merger-FIFO write side (dout/enq/full).
interface sorter_leaf_buffer_if import sorter_pkg::*; #(
    parameter int unsigned DW = DW_DEFAULT
);
    // Handshake: a word moves on a cycle where its strobe (i_enq / enq) is high and the
    // receiver's full flag (i_full / full) is low in that same cycle; no other transfer exists.
    logic [DW-1:0] din;
    logic          i_enq;
    logic          i_full;
    logic          full;
    logic          enq;
    logic [DW-1:0] dout;

    modport master (output din, i_enq, full, input i_full, enq, dout);
    modport slave  (input din, i_enq, full, output i_full, enq, dout);
endinterface

// File: rtl/sorter_leaf_buffer_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head is valid combinationally whenever not empty.
module sync_fifo_fwft #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr,
    input  logic [DW-1:0]            i_din,
    input  logic                     i_rd,
    output logic [DW-1:0]            o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic          w_do_rd;
    logic          w_do_wr;

    // Extra pointer bit tells full from empty when the index bits match.
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_count = r_wp - r_rp;
    assign o_head  = r_mem[r_rp[AW-1:0]];

    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_wr) r_wp <= r_wp + PTR_ONE;
            if (w_do_rd) r_rp <= r_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wp[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/sorter_leaf_buffer.sv
// Leaf input buffer: forwards exactly cfg_len buffered records per run, then pads with
// the sentinel until the next run; flags dropped upstream writes.
module sorter_leaf_buffer import sorter_pkg::*; #(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sorter_leaf_buffer_if.slave      bus,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     next_run,
    output logic                     run_done,
    output logic                     overflow,
    output leaf_state_t              o_dbg_state,
    output logic [$clog2(DEPTH):0]   o_dbg_count
);
    localparam logic [SENT_MAX_W-1:0] SENT_WIDE = sentinel_word(DW);
    localparam logic [DW-1:0]         SENTINEL  = SENT_WIDE[DW-1:0];
    localparam logic [LEN_W-1:0]      LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    leaf_state_t      r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_overflow;

    logic             w_pop;
    logic             w_wr;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [DW-1:0]    w_head;

    sync_fifo_fwft #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_wr),
        .i_din   (bus.din),
        .i_rd    (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_dbg_count)
    );

    // A same-cycle pop frees a slot, so a full FIFO still accepts while draining.
    assign w_pop      = (r_state == ST_FILL) && !bus.full && !w_fifo_empty;
    assign bus.i_full = w_fifo_full && !w_pop;
    assign w_wr       = bus.i_enq && !bus.i_full;

    assign bus.enq    = w_pop || ((r_state == ST_PAD) && !bus.full);
    assign bus.dout   = (r_state == ST_FILL) ? w_head : SENTINEL;
    assign run_done   = (r_state == ST_PAD);
    assign overflow   = r_overflow;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_PAD: begin
                    if (next_run) begin
                        r_rem   <= cfg_len;
                        r_state <= (cfg_len == '0) ? ST_PAD : ST_FILL;
                    end
                end
                ST_FILL: begin
                    // next_run is deliberately ignored until the run completes.
                    if (w_pop && (r_rem != '0)) begin
                        r_rem <= r_rem - LEN_ONE;
                        if (r_rem == LEN_ONE) r_state <= ST_PAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_overflow <= 1'b0;
        else if (bus.i_enq && bus.i_full)  r_overflow <= 1'b1;
    end

endmodule
